ir_transmitter_fifo: RTL and testbench

//  Parametrised IrDA-SIR transmitter: buffers words in a TX FIFO and serialises each one as an

---
 rtl/ir_transmitter_fifo.sv | 167 ++++++++++++++++
 tb/tb_ir_transmitter_fifo.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_transmitter_fifo.sv
// IrDA-SIR transmitter with a TX FIFO: each buffered word is framed as start, LSB-first data,
// optional parity and stop bits, and every logic-0 bit is sent as a short high pulse.
module ir_transmitter_fifo #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int CLK_PER_BIT = 16,
    parameter int PULSE_CLKS  = 3,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          data,
    input  logic                          send,
    output logic                          ready,
    output logic                          tx_data_out,
    output logic                          tx_idle,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLK_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] PULSE_LIM = BAUD_W'(PULSE_CLKS);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_next;
    logic [BAUD_W-1:0]     baud_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_BITS-1:0]  shift;
    logic                  par_bit;
    logic                  cur_bit;
    logic                  bit_end;
    logic                  pop;
    logic                  push;
    logic                  full;
    logic                  empty;
    logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    function automatic logic frame_parity(input logic [DATA_BITS-1:0] w);
        frame_parity = (^w) ^ (PARITY_MODE == 2);
    endfunction

    assign full    = (fifo_count == FULL_CNT);
    assign empty   = (fifo_count == '0);
    assign ready   = !full;
    assign push    = send && !full;
    assign tx_idle = (state == IDLE) && empty;
    assign bit_end = (baud_cnt == BAUD_LAST);

    // FIFO storage carries data only, so it is never cleared
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (!push && pop) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
            if (send && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        cur_bit    = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                cur_bit = 1'b0;
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                cur_bit = shift[0];
                if (bit_end && bit_cnt == DATA_LAST) begin
                    state_next = (PARITY_MODE != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                cur_bit = par_bit;
                if (bit_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                // Popping on the last stop clock chains the next frame with no idle gap
                if (bit_end && bit_cnt == STOP_LAST) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            tx_data_out <= 1'b0;
        end else begin
            state       <= state_next;
            tx_data_out <= !cur_bit && (baud_cnt < PULSE_LIM);
            if (state == IDLE || bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + BAUD_W'(1);
            end
            if (state_next != state) begin
                bit_cnt <= '0;
            end else if (bit_end) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (pop) begin
            shift   <= mem[rd_ptr];
            par_bit <= frame_parity(mem[rd_ptr]);
        end else if (state == DATA && bit_end) begin
            shift <= shift >> 1;
        end
    end

endmodule

// File: tb/tb_ir_transmitter_fifo.sv
// Scoreboard bench for ir_transmitter_fifo: three parameterisations, a timing-level model of
// FIFO occupancy and frame scheduling, and a waveform monitor that checks each frame's pulses.
module tb_ir_transmitter_fifo;

    localparam int DEPTH = 4;

    typedef struct {
        int w;
        int start;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       send  = 1'b0;
    logic [7:0] data  = 8'h00;
    logic [2:0] send_v;
    logic [2:0] ready_v;
    logic [2:0] tx_v;
    logic [2:0] idle_v;
    logic [2:0] ovf_v;
    logic [8:0] cnt_all;

    int p_db  [3] = '{8, 8, 7};
    int p_pm  [3] = '{1, 2, 1};
    int p_sb  [3] = '{1, 1, 2};
    int p_cpb [3] = '{16, 16, 8};
    int p_pc  [3] = '{3, 3, 2};

    int   sel      = 0;
    bit   mon_en   = 1'b0;
    int   edge_n   = 0;
    int   checks   = 0;
    int   passes   = 0;
    int   frames   = 0;
    int   ovf_edge = -1;
    int   acc_w [$];
    int   pop_e [$];
    exp_t exp_q [$];

    bit   in_frame = 1'b0;
    int   off, flen, errs, first_bad, got_start;
    exp_t cur;
    logic pat [256];

    assign send_v = {send && sel == 2, send && sel == 1, send && sel == 0};

    ir_transmitter_fifo #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1),
                          .CLK_PER_BIT(16), .PULSE_CLKS(3), .FIFO_DEPTH(DEPTH)) dut0 (
        .clock(clock), .reset(reset), .data(data), .send(send_v[0]), .ready(ready_v[0]),
        .tx_data_out(tx_v[0]), .tx_idle(idle_v[0]), .overflow(ovf_v[0]), .fifo_count(cnt_all[2:0]));

    ir_transmitter_fifo #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1),
                          .CLK_PER_BIT(16), .PULSE_CLKS(3), .FIFO_DEPTH(DEPTH)) dut1 (
        .clock(clock), .reset(reset), .data(data), .send(send_v[1]), .ready(ready_v[1]),
        .tx_data_out(tx_v[1]), .tx_idle(idle_v[1]), .overflow(ovf_v[1]), .fifo_count(cnt_all[5:3]));

    ir_transmitter_fifo #(.DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2),
                          .CLK_PER_BIT(8), .PULSE_CLKS(2), .FIFO_DEPTH(DEPTH)) dut2 (
        .clock(clock), .reset(reset), .data(data[6:0]), .send(send_v[2]), .ready(ready_v[2]),
        .tx_data_out(tx_v[2]), .tx_idle(idle_v[2]), .overflow(ovf_v[2]), .fifo_count(cnt_all[8:6]));

    always #5 clock = ~clock;

    always @(posedge clock) edge_n <= edge_n + 1;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0d, expected %0d (edge %0d, dut %0d)", name, act, req, edge_n, sel);
    endtask

    function automatic int cnt_of(input int s);
        return int'(cnt_all[s*3 +: 3]);
    endfunction

    function automatic int frame_len(input int s);
        return (1 + p_db[s] + ((p_pm[s] != 0) ? 1 : 0) + p_sb[s]) * p_cpb[s];
    endfunction

    // Words buffered after edge e: accepted writes so far minus pops so far
    function automatic int occ_after(input int e);
        int o;
        o = 0;
        foreach (acc_w[i]) if (acc_w[i] <= e) o++;
        foreach (pop_e[i]) if (pop_e[i] <= e) o--;
        return o;
    endfunction

    function automatic bit busy_after(input int e);
        foreach (pop_e[i]) if (pop_e[i] <= e && e < pop_e[i] + frame_len(sel)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic build(input int w);
        int nb, ones;
        int bits [16];
        bits[0] = 0;
        nb = 1;
        ones = 0;
        for (int i = 0; i < p_db[sel]; i++) begin
            bits[nb] = (w >> i) & 1;
            ones += bits[nb];
            nb++;
        end
        if (p_pm[sel] != 0) begin
            bits[nb] = (ones % 2) ^ ((p_pm[sel] == 2) ? 1 : 0);
            nb++;
        end
        for (int i = 0; i < p_sb[sel]; i++) begin
            bits[nb] = 1;
            nb++;
        end
        flen = nb * p_cpb[sel];
        for (int j = 0; j < flen; j++)
            pat[j] = (bits[j / p_cpb[sel]] == 0) && ((j % p_cpb[sel]) < p_pc[sel]);
    endtask

    // One cycle of stimulus; a write is predicted to pop at max(write+1, previous pop + frame)
    task automatic send_cycle(input bit s, input logic [7:0] w);
        int e, p;
        logic [7:0] m;
        if (s) begin
            e = edge_n + 1;
            send = 1'b1;
            data = w;
            if (occ_after(e - 1) >= DEPTH) begin
                if (ovf_edge < 0) ovf_edge = e;
            end else begin
                m = w & 8'((1 << p_db[sel]) - 1);
                p = e + 1;
                if (pop_e.size() > 0 && pop_e[$] + frame_len(sel) > p) p = pop_e[$] + frame_len(sel);
                acc_w.push_back(e);
                pop_e.push_back(p);
                exp_q.push_back('{w: int'(m), start: p + 1});
            end
        end
        @(posedge clock);
        #1;
        send = 1'b0;
    endtask

    task automatic clear_model();
        acc_w.delete();
        pop_e.delete();
        exp_q.delete();
        ovf_edge = -1;
    endtask

    task automatic do_reset(input int s);
        mon_en = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        clear_model();
        sel = s;
        mon_en = 1'b1;
    endtask

    task automatic drain();
        int target;
        target = edge_n + 3;
        if (pop_e.size() > 0 && pop_e[$] + frame_len(sel) + 3 > target)
            target = pop_e[$] + frame_len(sel) + 3;
        while (edge_n < target) begin
            @(posedge clock);
            #1;
        end
        chk(exp_q.size() == 0 && !in_frame, "drain_pending_frames", exp_q.size(), 0);
    endtask

    initial begin : monitor
        bit t;
        forever begin
            @(negedge clock);
            if (!mon_en) begin
                in_frame = 1'b0;
            end else begin
                t = tx_v[sel];
                if (!in_frame && t) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_pulse", int'(t), 0);
                    end else begin
                        cur = exp_q.pop_front();
                        build(cur.w);
                        in_frame = 1'b1;
                        off = 0;
                        errs = 0;
                        first_bad = -1;
                        got_start = edge_n;
                    end
                end
                if (in_frame) begin
                    if (t != pat[off]) begin
                        errs++;
                        if (first_bad < 0) first_bad = off;
                    end
                    off++;
                    if (off == flen) begin
                        in_frame = 1'b0;
                        frames++;
                        chk(got_start == cur.start, "frame_start_edge", got_start, cur.start);
                        chk(errs == 0, $sformatf("frame_shape_w%02h_first_bad_offset", cur.w), first_bad, -1);
                    end
                end
            end
        end
    end

    initial begin : status
        int e, o;
        bit busy, ovf_exp;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                e = edge_n;
                o = occ_after(e);
                busy = busy_after(e);
                ovf_exp = (ovf_edge >= 0) && (e >= ovf_edge);
                chk(cnt_of(sel) == o, "fifo_count", cnt_of(sel), o);
                chk(ready_v[sel] == (o != DEPTH), "ready", int'(ready_v[sel]), int'(o != DEPTH));
                chk(idle_v[sel] == (!busy && o == 0), "tx_idle", int'(idle_v[sel]), int'(!busy && o == 0));
                chk(ovf_v[sel] == ovf_exp, "overflow", int'(ovf_v[sel]), int'(ovf_exp));
            end
        end
    end

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded its time budget, got edge %0d", edge_n);
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1);
    end

    initial begin : stimulus
        int f0, p0, gap, burst;
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int s = 0; s < 3; s++) begin
            chk(tx_v[s] == 1'b0, "reset_tx_data_out", int'(tx_v[s]), 0);
            chk(idle_v[s] == 1'b1, "reset_tx_idle", int'(idle_v[s]), 1);
            chk(ready_v[s] == 1'b1, "reset_ready", int'(ready_v[s]), 1);
            chk(ovf_v[s] == 1'b0, "reset_overflow", int'(ovf_v[s]), 0);
            chk(cnt_of(s) == 0, "reset_fifo_count", cnt_of(s), 0);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        clear_model();
        sel = 0;
        mon_en = 1'b1;
        repeat (100) send_cycle(1'b0, 8'h00);

        send_cycle(1'b1, 8'h55);
        drain();

        do_reset(1);
        send_cycle(1'b1, 8'hFF);
        drain();

        do_reset(0);
        send_cycle(1'b1, 8'h01);
        send_cycle(1'b1, 8'h02);
        send_cycle(1'b1, 8'h03);
        drain();

        do_reset(0);
        f0 = frames;
        repeat (6) send_cycle(1'b1, 8'($urandom));
        drain();
        chk(frames - f0 == 5, "overflow_burst_frames", frames - f0, 5);

        // Abort mid-frame at a point where a data pulse would otherwise be on the line
        do_reset(0);
        repeat (6) send_cycle(1'b1, 8'h00);
        p0 = pop_e[0];
        while (edge_n < p0 + 48) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        mon_en = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk(tx_v[0] == 1'b0, "abort_tx_data_out", int'(tx_v[0]), 0);
        chk(idle_v[0] == 1'b1, "abort_tx_idle", int'(idle_v[0]), 1);
        chk(cnt_of(0) == 0, "abort_fifo_count", cnt_of(0), 0);
        chk(ovf_v[0] == 1'b0, "abort_overflow", int'(ovf_v[0]), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        clear_model();
        f0 = frames;
        mon_en = 1'b1;
        repeat (300) send_cycle(1'b0, 8'h00);
        chk(frames == f0, "abort_no_new_frames", frames - f0, 0);

        do_reset(2);
        send_cycle(1'b1, 8'h2A);
        send_cycle(1'b1, 8'h7F);
        drain();

        for (int s = 0; s < 3; s++) begin
            do_reset(s);
            repeat (12) begin
                gap = $urandom_range(0, 250);
                repeat (gap) send_cycle(1'b0, 8'h00);
                burst = $urandom_range(1, 3);
                repeat (burst) send_cycle(1'b1, 8'($urandom));
            end
            drain();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
